// File: rtl/spi_arb_pkg.sv
// Shared types and index helpers for the SPI round-robin arbiter.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Successor of idx in a ring of len slots; works for non-power-of-two len.
  function automatic int unsigned next_ptr(int unsigned idx, int unsigned len);
    return (idx + 1 >= len) ? 0 : idx + 1;
  endfunction

  // (a + b) mod len for a, b < len.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned len);
    int unsigned s;
    s = a + b;
    return (s >= len) ? s - len : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic [LEN-1:0]         req,
  input  logic [$clog2(LEN)-1:0] ptr,
  output logic [LEN-1:0]         pick_onehot,
  output logic                   any
);

  localparam int IDX_W = $clog2(LEN);

  logic [LEN-1:0] rot;
  logic           found;

  // Rotate so ptr lands on bit 0, find first set, then map back to the real index.
  always_comb begin
    rot         = '0;
    pick_onehot = '0;
    found       = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      rot[i] = req[IDX_W'(wrap_add(i, 32'(ptr), LEN))];
    end
    for (int j = 0; j < LEN; j++) begin
      if (rot[j] && !found) begin
        found = 1'b1;
        pick_onehot[IDX_W'(wrap_add(j, 32'(ptr), LEN))] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter for the shared SPI execution unit with hold timeout.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int LEN      = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [LEN-1:0] i_req,
  input  logic           i_done,
  output logic [LEN-1:0] o_grant,
  output logic           o_valid,
  output logic           o_timeout
);

  localparam int IDX_W = $clog2(LEN);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_HOLD);

  arb_state_t       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] gidx, gidx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [LEN-1:0]   grant_n;
  logic             valid_n;
  logic             timeout_n;

  logic [LEN-1:0]   pick;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;

  rr_pick #(.LEN(LEN)) u_pick (
    .req        (i_req),
    .ptr        (ptr),
    .pick_onehot(pick),
    .any        (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < LEN; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign owner_req = i_req[gidx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      cnt       <= '0;
      o_grant   <= '0;
      o_valid   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gidx      <= gidx_n;
      cnt       <= cnt_n;
      o_grant   <= grant_n;
      o_valid   <= valid_n;
      o_timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gidx_n    = gidx;
    cnt_n     = cnt;
    grant_n   = o_grant;
    valid_n   = o_valid;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grant_n = pick;
          valid_n = 1'b1;
          gidx_n  = pick_idx;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // Done wins over a dropped request, which wins over the hold timeout.
        if (i_done || !owner_req || cnt == CNT_LAST) begin
          grant_n   = '0;
          valid_n   = 1'b0;
          timeout_n = !i_done && owner_req;
          ptr_n     = IDX_W'(next_ptr(32'(gidx), LEN));
          state_n   = RELEASE;
        end else if (cnt != CNT_SAT) begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Bench for spi_rr_arbiter: directed vector table, corner sequences, random vs. model.
module tb_spi_rr_arbiter;

  localparam int LEN      = 4;
  localparam int MAX_HOLD = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [LEN-1:0] req;
  logic           done;
  logic [LEN-1:0] grant;
  logic           valid;
  logic           timeout;

  int n_vec = 0;
  int n_bad = 0;

  spi_rr_arbiter #(.LEN(LEN), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_done   (done),
    .o_grant  (grant),
    .o_valid  (valid),
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how long it has held, and the idle gap left.
  int m_owner = -1;
  int m_held  = 0;
  int m_cool  = 0;
  int m_start = 0;
  bit m_tmo   = 1'b0;

  function automatic logic [LEN-1:0] m_grant();
    logic [LEN-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    m_tmo = 1'b0;
    if (rst) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_start = 0;
    end else if (m_owner >= 0) begin
      m_held++;
      if (done || !req[m_owner] || m_held == MAX_HOLD) begin
        m_tmo   = !done && req[m_owner];
        m_start = (m_owner + 1) % LEN;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else begin
      for (int k = 0; k < LEN; k++) begin
        if (m_owner < 0 && req[(m_start + k) % LEN]) m_owner = (m_start + k) % LEN;
      end
      m_held = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got grant=%b valid=%b timeout=%b, want grant=%b valid=%b timeout=%b",
               name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic       v;
    logic       t;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] q, logic d, logic [3:0] g, logic v, logic t);
    vec_t x;
    x.rst = r; x.req = q; x.done = d; x.g = g; x.v = v; x.t = t;
    return x;
  endfunction

  vec_t tbl[19];

  // Grant requester 1 (with requester 2 also asking) and let the hold run out.
  task automatic hold_case(input bit with_done);
    int held;
    string tag;
    tag  = with_done ? "done_at_timeout" : "timeout";
    rst  = 1'b1; req = 4'b0110; done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check({tag, "_grant"}, {grant, valid, timeout}, {4'b0010, 1'b1, 1'b0});
    held = 1;
    for (int c = 0; c < MAX_HOLD - 1; c++) begin
      tick();
      if (valid && grant == 4'b0010) held++;
    end
    check_int({tag, "_held_cycles"}, held, MAX_HOLD);
    done = with_done;
    tick();
    done = 1'b0;
    check({tag, "_release"}, {grant, valid, timeout}, {4'b0000, 1'b0, !with_done});
    tick();
    check({tag, "_gap"}, {grant, valid, timeout}, {4'b0000, 1'b0, 1'b0});
    tick();
    tick();
    check({tag, "_next"}, {grant, valid, timeout}, {4'b0100, 1'b1, 1'b0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros;
    int pr, pd;
    logic [3:0] exp_g;

    rst = 1'b1; req = '0; done = 1'b0;

    tbl[0]  = mk(1, 4'b1111, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(1, 4'b1111, 0, 4'b0000, 0, 0);
    tbl[2]  = mk(0, 4'b1111, 0, 4'b0001, 1, 0);
    tbl[3]  = mk(0, 4'b1111, 0, 4'b0001, 1, 0);
    tbl[4]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0);
    tbl[5]  = mk(0, 4'b1111, 0, 4'b0000, 0, 0);
    tbl[6]  = mk(0, 4'b1111, 0, 4'b0010, 1, 0);
    tbl[7]  = mk(0, 4'b1111, 1, 4'b0000, 0, 0);
    tbl[8]  = mk(0, 4'b1111, 0, 4'b0000, 0, 0);
    tbl[9]  = mk(0, 4'b1111, 0, 4'b0100, 1, 0);
    tbl[10] = mk(0, 4'b1011, 0, 4'b0000, 0, 0);
    tbl[11] = mk(0, 4'b1011, 0, 4'b0000, 0, 0);
    tbl[12] = mk(0, 4'b1011, 0, 4'b1000, 1, 0);
    tbl[13] = mk(1, 4'b1010, 0, 4'b0000, 0, 0);
    tbl[14] = mk(0, 4'b1010, 0, 4'b0010, 1, 0);
    tbl[15] = mk(0, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[16] = mk(0, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[17] = mk(0, 4'b0000, 0, 4'b0000, 0, 0);
    tbl[18] = mk(0, 4'b0001, 1, 4'b0001, 1, 0);

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; done = tbl[i].done;
      tick();
      check($sformatf("vec%0d", i), {grant, valid, timeout}, {tbl[i].g, tbl[i].v, tbl[i].t});
    end

    // Back-to-back rotation with all requesters active, done three cycles after each grant.
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    tick();
    rst   = 1'b0;
    zeros = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      while (!valid && zeros < 10) begin
        zeros++;
        tick();
      end
      exp_g = 4'b0001 << (n % 4);
      check($sformatf("rr_grant%0d", n), {grant, valid, timeout}, {exp_g, 1'b1, 1'b0});
      check_int($sformatf("rr_gap%0d", n), zeros, (n == 0) ? 0 : 2);
      tick();
      tick();
      done = 1'b1;
      tick();
      done  = 1'b0;
      zeros = valid ? 0 : 1;
    end

    hold_case(1'b0);
    hold_case(1'b1);

    // Random traffic: busy phase first, then long holds so timeouts occur.
    rst = 1'b1; req = '0; done = 1'b0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      pr = (c < 1500) ? 3 : 31;
      pd = (c < 1500) ? 9 : 39;
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, pr) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, pd) == 0);
      tick();
      check($sformatf("rand%0d", c), {grant, valid, timeout},
            {m_grant(), (m_owner >= 0), m_tmo});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
